noc_credit_tx: RTL

//  Transmit end of one NoC dynamic-network link (dynN_dXo / dXo_valid / dXo_yummy), the sender matching a tile input port.

---
 rtl/noc_credit_tx_if.sv | 23 ++
 rtl/noc_credit_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/noc_credit_tx_if.sv
// Link-side and local-source signals of one NoC credit transmitter.
// The transmitter sits on the slave modport. The environment that feeds flits
// and acts as the neighbour receiver sits on the master modport.
interface noc_credit_tx_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_val;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  yummy_in;

  modport master (
    output in_data, in_val, yummy_in,
    input  in_rdy, dout, dout_valid
  );

  modport slave (
    input  in_data, in_val, yummy_in,
    output in_rdy, dout, dout_valid
  );
endinterface

// File: rtl/noc_credit_tx.sv
// Credit-based transmit end of one NoC dynamic-network link.
// Local flits are buffered in a small FIFO. Each flit is issued only while a
// receiver credit is available, and every yummy pulse gives one credit back.
// Header length fields are followed so the block knows when a packet is in flight.
// Optional feature: define NOC_TX_STATS_EN to build the sent-flit and stall counters.
// Without that define, stat_flits and stat_stalls are tied to zero.
module noc_credit_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int CREDITS    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_LSB    = 22,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_credit_tx_if.slave       link,
  output logic                 pkt_active,
  output logic                 tx_idle,
  output logic                 credit_err,
  output logic [31:0]          stat_flits,
  output logic [31:0]          stat_stalls
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [AW:0]   FULL_COUNT  = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] MAX_CREDITS = CREDITS[CW-1:0];

  typedef enum logic {HDR, BODY} frameState_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wrPtr;
  logic [AW-1:0]         rdPtr;
  logic [AW:0]           count;
  logic [CW-1:0]         credits;
  logic [DATA_WIDTH-1:0] doutReg;
  logic                  doutValidReg;
  logic                  creditErrReg;
  frameState_t           state;
  frameState_t           stateNext;
  logic [LEN_WIDTH-1:0]  remain;
  logic [LEN_WIDTH-1:0]  remainNext;
  logic                  full;
  logic                  empty;
  logic                  wrEn;
  logic                  sendEn;
  logic [DATA_WIDTH-1:0] headFlit;
  logic [LEN_WIDTH-1:0]  hdrLen;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign wrEn     = link.in_val && link.in_rdy;
  assign sendEn   = !empty && (credits != '0);
  assign headFlit = mem[rdPtr];
  assign hdrLen   = headFlit[LEN_LSB +: LEN_WIDTH];

  assign link.in_rdy     = !rst && !full;
  assign link.dout       = doutReg;
  assign link.dout_valid = doutValidReg;
  assign credit_err      = creditErrReg;
  assign tx_idle         = empty && (credits == MAX_CREDITS) && !pkt_active;

  // The storage array holds no reset value, because the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrPtr] <= link.in_data;
    end
  end

  // FIFO pointers and occupancy. A reset drops anything still buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (sendEn) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({wrEn, sendEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Link output register. dout keeps the last flit sent, and valid pulses once per flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      doutReg      <= '0;
      doutValidReg <= 1'b0;
    end else begin
      doutValidReg <= sendEn;
      if (sendEn) begin
        doutReg <= headFlit;
      end
    end
  end

  // Credit counter. A yummy that arrives while credits are full saturates the counter and flags an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits      <= MAX_CREDITS;
      creditErrReg <= 1'b0;
    end else begin
      case ({sendEn, link.yummy_in})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == MAX_CREDITS) begin
            creditErrReg <= 1'b1;
          end else begin
            credits <= credits + 1'b1;
          end
        end
        default: credits <= credits;
      endcase
    end
  end

  // Framing state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HDR;
      remain <= '0;
    end else begin
      state  <= stateNext;
      remain <= remainNext;
    end
  end

  // Framing next state. It moves forward only on flits that are actually sent.
  always_comb begin
    stateNext  = state;
    remainNext = remain;
    if (sendEn) begin
      case (state)
        HDR: begin
          if (hdrLen != '0) begin
            stateNext  = BODY;
            remainNext = hdrLen;
          end
        end
        BODY: begin
          remainNext = remain - 1'b1;
          if (remain == LEN_WIDTH'(1)) begin
            stateNext = HDR;
          end
        end
        default: stateNext = HDR;
      endcase
    end
  end

  // Framing outputs.
  always_comb begin
    pkt_active = (state == BODY);
  end

`ifdef NOC_TX_STATS_EN
  logic [31:0] flitCount;
  logic [31:0] stallCount;

  // Activity counters. They wrap naturally and are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      flitCount  <= '0;
      stallCount <= '0;
    end else begin
      if (sendEn) begin
        flitCount <= flitCount + 1'b1;
      end
      if (!empty && (credits == '0)) begin
        stallCount <= stallCount + 1'b1;
      end
    end
  end

  assign stat_flits  = flitCount;
  assign stat_stalls = stallCount;
`else
  assign stat_flits  = '0;
  assign stat_stalls = '0;
`endif

endmodule
